// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - saturating frame accumulator for signed multiplier products
`timescale 1ns/1ps
module mac_accumulator #(
    parameter int DATA_WIDTH = 9,
    parameter int PROD_WIDTH = 2 * DATA_WIDTH,
    parameter int ACC_WIDTH  = 24,
    parameter int N_TERMS    = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         start_in,
    input  logic signed [PROD_WIDTH-1:0] producto_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic signed [ACC_WIDTH-1:0]  acumulado_out,
    output logic                         valid_out,
    output logic                         overflow_out,
    output logic                         busy_out
);

    // One extra counter bit so the last-term index never wraps, even for N_TERMS a power of two.
    localparam int CNT_WIDTH = $clog2(N_TERMS) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_TERMS - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACUM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic                         r_ovf;

    logic                         w_accept;
    logic                         w_start;
    logic signed [ACC_WIDTH:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]  w_sat;
    logic                         w_clamp;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        w_next    = r_state;
        ready_out = 1'b0;
        busy_out  = 1'b0;
        valid_out = 1'b0;
        w_start   = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = start_in;
                if (start_in) begin
                    w_next = ACUM;
                end
            end
            ACUM: begin
                ready_out = 1'b1;
                busy_out  = 1'b1;
                w_accept  = valid_in;
                if (valid_in && (r_cnt == LAST_IDX)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                valid_out = 1'b1;
                busy_out  = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Widened sum: the top two bits disagree exactly when the ACC_WIDTH result overflowed.
    always_comb begin
        w_sum   = {r_acc[ACC_WIDTH-1], r_acc}
                + {{(ACC_WIDTH + 1 - PROD_WIDTH){producto_in[PROD_WIDTH-1]}}, producto_in};
        w_clamp = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
        w_sat   = w_sum[ACC_WIDTH-1:0];
        if (w_clamp) begin
            w_sat = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    // Accumulator, term counter and sticky overflow; all cleared only by a frame start.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sat;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            r_ovf <= r_ovf | w_clamp;
        end
    end

    assign acumulado_out = r_acc;
    assign overflow_out  = r_ovf;

endmodule
